// File: rtl/mi_arbiter_2p.sv
// Two-port round-robin arbiter in front of the mi_* burst memory interface.
// One owner per burst; its command and beat strobes are routed, and beat counts are checked.
module mi_arbiter_2p #(
  parameter int unsigned AW = 20
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] p0_addr,
  input  logic [6:0]    p0_len,
  input  logic          p0_rw,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [31:0]   p0_wdata,
  output logic          p0_wack,
  output logic          p0_wlast,
  output logic [31:0]   p0_rdata,
  output logic          p0_rstb,
  output logic          p0_rlast,
  input  logic [AW-1:0] p1_addr,
  input  logic [6:0]    p1_len,
  input  logic          p1_rw,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [31:0]   p1_wdata,
  output logic          p1_wack,
  output logic          p1_wlast,
  output logic [31:0]   p1_rdata,
  output logic          p1_rstb,
  output logic          p1_rlast,
  output logic [AW-1:0] m_addr,
  output logic [6:0]    m_len,
  output logic          m_rw,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_wdata,
  input  logic          m_wack,
  input  logic          m_wlast,
  input  logic          m_rstb,
  input  logic          m_rlast,
  input  logic [31:0]   m_rdata,
  output logic [1:0]    grant,
  output logic          len_err
);

  localparam int unsigned LW = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [LW-1:0] len_q, len_d;
  logic          rw_q, rw_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic          len_err_q, len_err_d;

  logic own_valid, any_stb, beat, last, wrong_dir;
  logic wack_c, wlast_c, rstb_c, rlast_c;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= '0;
      rw_q         <= 1'b0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      rw_q         <= rw_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  assign len_err   = len_err_q;
  assign p0_rdata  = m_rdata;
  assign p1_rdata  = m_rdata;
  assign own_valid = owner_q ? p1_valid : p0_valid;
  assign any_stb   = m_wack | m_wlast | m_rstb | m_rlast;

  // Direction-qualified view of the downstream strobes for the latched burst
  assign wack_c    = !rw_q & m_wack;
  assign wlast_c   = !rw_q & m_wlast;
  assign rstb_c    = rw_q & m_rstb;
  assign rlast_c   = rw_q & m_rlast;
  assign beat      = wack_c | rstb_c;
  assign last      = wlast_c | rlast_c;
  assign wrong_dir = rw_q ? (m_wack | m_wlast) : (m_rstb | m_rlast);

  // Next-state and combinational routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    rw_d         = rw_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = 1'b0;
    grant        = 2'b00;
    m_addr       = '0;
    m_len        = '0;
    m_rw         = 1'b0;
    m_valid      = 1'b0;
    m_wdata      = p0_wdata;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    p0_wack      = 1'b0;
    p0_wlast     = 1'b0;
    p0_rstb      = 1'b0;
    p0_rlast     = 1'b0;
    p1_wack      = 1'b0;
    p1_wlast     = 1'b0;
    p1_rstb      = 1'b0;
    p1_rlast     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        len_err_d = any_stb;
        if (p0_valid || p1_valid) begin
          // On a tie the port that did not own the last burst wins
          owner_d = (p0_valid && p1_valid) ? !last_owner_q : p1_valid;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        len_err_d = any_stb;
        grant     = owner_q ? 2'b10 : 2'b01;
        m_addr    = owner_q ? p1_addr : p0_addr;
        m_len     = owner_q ? p1_len : p0_len;
        m_rw      = owner_q ? p1_rw : p0_rw;
        m_valid   = own_valid;
        p0_ready  = !owner_q & m_ready;
        p1_ready  = owner_q & m_ready;
        if (own_valid && m_ready) begin
          len_d        = m_len;
          rw_d         = m_rw;
          beat_cnt_d   = '0;
          last_owner_d = owner_q;
          state_d      = ST_DATA;
        end else if (!own_valid) begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        grant   = owner_q ? 2'b10 : 2'b01;
        m_wdata = owner_q ? p1_wdata : p0_wdata;
        if (owner_q) begin
          p1_wack  = wack_c;
          p1_wlast = wlast_c;
          p1_rstb  = rstb_c;
          p1_rlast = rlast_c;
        end else begin
          p0_wack  = wack_c;
          p0_wlast = wlast_c;
          p0_rstb  = rstb_c;
          p0_rlast = rlast_c;
        end
        if (beat) begin
          beat_cnt_d = beat_cnt_q + LW'(1);
        end
        len_err_d = wrong_dir | (last & (beat_cnt_q != len_q));
        if (last) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
